dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
Shares the single data_memory port between the CPU load/store unit (port C) and a DMA/debug loader (port D). The DMA/debug loader is used to preload or inspect memory while the core runs.
- Sits between cpu and data_memory; drives data_memory's wr_en/mem_ctrl/addr/data_in and returns data_out.
- CPU has priority. DMA is protected from starvation, may lock the port for bounded bursts, and the CPU is stalled when it loses arbitration.

Parameters:
STARVE_LIMIT, 8, consecutive cycles DMA may be denied while requesting before a forced DMA grant (>=1)
MAX_BURST, 16, maximum DMA transfers per locked burst (>=1)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU transfer request (valid)
cpu_wr_en  input  1  CPU write enable
cpu_mem_op  input  mem_op_t  CPU access size/sign
cpu_addr  input  32  CPU address
cpu_wdata  input  32  CPU write data
cpu_gnt  output  1  CPU transfer accepted this cycle
cpu_rdata  output  32  CPU read data, valid when cpu_gnt
cpu_stall  output  1  cpu_req & ~cpu_gnt
dma_req  input  1  DMA transfer request
dma_lock  input  1  DMA requests exclusive burst ownership
dma_wr_en  input  1  DMA write enable
dma_mem_op  input  mem_op_t  DMA access size/sign
dma_addr  input  32  DMA address
dma_wdata  input  32  DMA write data
dma_gnt  output  1  DMA transfer accepted this cycle
dma_rdata  output  32  DMA read data, valid when dma_gnt
mem_wr_en  output  1  to data_memory wr_en
mem_op  output  mem_op_t  to data_memory mem_ctrl
mem_addr  output  32  to data_memory addr
mem_data_in  output  32  to data_memory data_in
mem_data_out  input  32  from data_memory data_out (combinational read)
cpu_xfer_cnt, dma_xfer_cnt, cpu_stall_cnt  output  CNT_W each  statistics (see Optional Feature)

Behaviour:
Handshake:
- Valid/ready. Transfer occurs in a cycle where req & gnt.
- Requester holds req and all fields stable until gnt; it must not drop req before gnt.
- Write commits at the rising edge ending the grant cycle.
- Read data is combinational from mem_data_out in the grant cycle. Zero added latency.

Datapath:
- At most one gnt per cycle.
- mem_addr/mem_op/mem_data_in are muxed from the DMA port when dma_gnt, otherwise from the CPU port.
- mem_wr_en = selected wr_en & (cpu_gnt | dma_gnt); 0 with no grant.
- cpu_rdata and dma_rdata both equal mem_data_out.

While reset is high:
- cpu_gnt = dma_gnt = mem_wr_en = 0.
- State NORMAL; starve_cnt, burst_cnt and statistics counters = 0.

State machine:
- NORMAL
  - cpu_req → grant CPU.
  - Else dma_req → grant DMA.
  - If dma_req denied: starve_cnt++. When starve_cnt reaches STARVE_LIMIT → FORCE_DMA.
  - DMA granted with dma_lock=1 → LOCKED, burst_cnt=1.
- FORCE_DMA
  - Grant DMA unconditionally (CPU stalls); clear starve_cnt.
  - dma_lock=1 → LOCKED with burst_cnt=1; else → NORMAL.
  - If dma_req dropped (illegal but tolerated): no grant, → NORMAL.
- LOCKED
  - cpu_gnt=0. DMA granted on dma_req; each grant burst_cnt++.
  - A grant bringing burst_cnt to MAX_BURST → COOLDOWN.
  - dma_lock low in a cycle: that cycle arbitrates per NORMAL rules, next state NORMAL.
- COOLDOWN
  - One cycle, dma_gnt=0, CPU granted if cpu_req, then → NORMAL.
- starve_cnt clears whenever DMA is granted or dma_req=0. burst_cnt clears on leaving LOCKED.
- Reset mid-burst or mid-FORCE returns to NORMAL. No transfer occurs in the reset cycle.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - cpu_xfer_cnt increments on cpu_req&cpu_gnt.
  - dma_xfer_cnt increments on dma_req&dma_gnt.
  - cpu_stall_cnt increments on cpu_stall.
  - All saturate at all-ones and clear on reset.
- Undefined: counter ports remain present and are tied to 0; no counter flops are built.

Test Plan:
1. CPU-only:
   - sw 0xDEADBEEF to 0x100, then lw 0x100.
   - Required: cpu_gnt same cycle each; cpu_rdata=0xDEADBEEF; cpu_stall=0 throughout.
2. Simultaneous single requests, CPU lw 0x10 and DMA sw 0x20:
   - Required: CPU granted cycle 0, DMA granted cycle 1.
   - Required: mem_wr_en only in cycle 1.
3. Starvation:
   - CPU req held high continuously, DMA req high from cycle 0, STARVE_LIMIT=8.
   - Required: dma_gnt=0 cycles 0–7, dma_gnt=1 in cycle 8, cpu_stall=1 in cycle 8.
4. Locked burst:
   - dma_lock=1, 20 DMA writes 0x200+4i, MAX_BURST=16, CPU requesting.
   - Required: 16 DMA grants back-to-back, then one COOLDOWN cycle with cpu_gnt=1, then DMA resumes.
5. Reset mid-burst:
   - Assert reset after 5 locked DMA beats.
   - Required: gnts=0 and mem_wr_en=0 during reset.
   - Required: after release with both requesting, CPU granted first.
6. With DMEM_ARB_STATS_EN:
   - Run scenario 3.
   - Required: cpu_xfer_cnt=8, dma_xfer_cnt=1, cpu_stall_cnt=1 after cycle 8.
   - Required without macro: all read 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares one data_memory port between the CPU (priority) and a DMA/debug loader (starvation-protected, lockable bursts).
// Zero-latency combinational grant and read data; the loser holds req. Statistics counters are built only when DMEM_ARB_STATS_EN is defined.
package dmem_arb_pkg;
  typedef logic [2:0] mem_op_t;
endpackage

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_wr_en,
  input  mem_op_t          cpu_mem_op,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_lock,
  input  logic             dma_wr_en,
  input  mem_op_t          dma_mem_op,
  input  logic [31:0]      dma_addr,
  input  logic [31:0]      dma_wdata,
  output logic             dma_gnt,
  output logic [31:0]      dma_rdata,
  output logic             mem_wr_en,
  output mem_op_t          mem_op,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out,
  output logic [CNT_W-1:0] cpu_xfer_cnt,
  output logic [CNT_W-1:0] dma_xfer_cnt,
  output logic [CNT_W-1:0] cpu_stall_cnt
);

  // starve_cnt may overshoot the limit by one after a COOLDOWN or unlocked-LOCKED denial.
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_FORCE,
    ST_LOCKED,
    ST_COOL
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          normal_arb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  assign normal_arb = (state == ST_NORMAL) || ((state == ST_LOCKED) && !dma_lock);

  always_comb begin
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    burst_nxt  = burst_cnt;
    if (!reset) begin
      if (normal_arb) begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req && !cpu_req;
      end else if (state == ST_COOL) begin
        cpu_gnt = cpu_req;
      end else begin
        dma_gnt = dma_req;
      end

      if (dma_gnt || !dma_req) starve_nxt = '0;
      else                     starve_nxt = starve_cnt + SW'(1);

      case (state)
        ST_NORMAL, ST_FORCE: begin
          if (dma_gnt && dma_lock) begin
            // The opening beat of a burst already counts toward MAX_BURST.
            if (MAX_BURST == 1) begin
              state_nxt = ST_COOL;
              burst_nxt = '0;
            end else begin
              state_nxt = ST_LOCKED;
              burst_nxt = BW'(1);
            end
          end else if ((state == ST_NORMAL) && !dma_gnt && dma_req &&
                       (starve_nxt >= SW'(STARVE_LIMIT))) begin
            state_nxt = ST_FORCE;
          end else begin
            state_nxt = ST_NORMAL;
          end
        end
        ST_LOCKED: begin
          if (!dma_lock) begin
            state_nxt = ST_NORMAL;
            burst_nxt = '0;
          end else if (dma_gnt) begin
            if (burst_cnt + BW'(1) >= BW'(MAX_BURST)) begin
              state_nxt = ST_COOL;
              burst_nxt = '0;
            end else begin
              burst_nxt = burst_cnt + BW'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_NORMAL;
          burst_nxt = '0;
        end
      endcase
    end
  end

  assign mem_addr    = dma_gnt ? dma_addr   : cpu_addr;
  assign mem_op      = dma_gnt ? dma_mem_op : cpu_mem_op;
  assign mem_data_in = dma_gnt ? dma_wdata  : cpu_wdata;
  assign mem_wr_en   = (dma_gnt ? dma_wr_en : cpu_wr_en) && (cpu_gnt || dma_gnt);
  assign cpu_rdata   = mem_data_out;
  assign dma_rdata   = mem_data_out;
  assign cpu_stall   = cpu_req && !cpu_gnt;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_xfer_cnt  <= '0;
      dma_xfer_cnt  <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      if (cpu_req && cpu_gnt && !(&cpu_xfer_cnt)) cpu_xfer_cnt <= cpu_xfer_cnt + CNT_W'(1);
      if (dma_req && dma_gnt && !(&dma_xfer_cnt)) dma_xfer_cnt <= dma_xfer_cnt + CNT_W'(1);
      if (cpu_stall && !(&cpu_stall_cnt))         cpu_stall_cnt <= cpu_stall_cnt + CNT_W'(1);
    end
  end
`else
  assign cpu_xfer_cnt  = '0;
  assign dma_xfer_cnt  = '0;
  assign cpu_stall_cnt = '0;
`endif

endmodule
